// File: rtl/score_pkg.sv
// score_pkg: shared font, cell geometry and types for the score renderer
//   GLYPH_W/CELL_W/GLYPH_H : glyph width, digit cell width (glyph + gap), glyph height in font pixels
//   FONT_3X5               : digit-major, row-major 3x5 font; bit 2 of a row is the leftmost column
//   conv_state_t           : binary-to-BCD converter states
//   bcd_t                  : one BCD digit; a score is bcd_t [DIGITS-1:0], index 0 = least significant
//   pow10                  : 10^n, used to derive the saturation limit from DIGITS
package score_pkg;

    localparam int GLYPH_W = 3;
    localparam int CELL_W  = 4;
    localparam int GLYPH_H = 5;

    localparam logic [0:9][0:4][2:0] FONT_3X5 = {
        15'b111_101_101_101_111,
        15'b010_110_010_010_111,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_t;

    typedef logic [3:0] bcd_t;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/score_bin2bcd.sv
// score_bin2bcd: per-player score capture, pending slot and sequential double-dabble converter
//   clk_i, rst_i : clock, asynchronous active-high reset
//   val_i        : binary score, saturated to 10^DIGITS-1 on capture
//   valid_i      : one-cycle load strobe
//   busy_o       : conversion running or pending
//   commit_o     : high during the COMMIT cycle; digits_o updates at the edge ending it
//   digits_o     : displayed BCD digits, index 0 = least significant
module score_bin2bcd
    import score_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int VAL_W  = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [VAL_W-1:0]  val_i,
    input  logic              valid_i,
    output logic              busy_o,
    output logic              commit_o,
    output bcd_t [DIGITS-1:0] digits_o
);

    localparam int MAX_VAL = pow10(DIGITS) - 1;
    localparam int CNT_W   = $clog2(VAL_W + 1);

    conv_state_t       state;
    logic [VAL_W-1:0]  sat;
    logic [VAL_W-1:0]  bin;
    logic [VAL_W-1:0]  pend_val;
    logic              pend_vld;
    logic [CNT_W-1:0]  cnt;
    bcd_t [DIGITS-1:0] bcd;
    bcd_t [DIGITS-1:0] adj;

    assign sat      = (int'(val_i) > MAX_VAL) ? VAL_W'(MAX_VAL) : val_i;
    assign busy_o   = (state != CONV_IDLE) || pend_vld;
    assign commit_o = (state == CONV_COMMIT);

    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) adj[d] = (bcd[d] >= 4'd5) ? bcd[d] + 4'd3 : bcd[d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= CONV_IDLE;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            pend_val <= '0;
            pend_vld <= 1'b0;
            digits_o <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (valid_i) begin
                        bin   <= sat;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    {bcd, bin} <= {adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(VAL_W - 1)) state <= CONV_COMMIT;
                    if (valid_i) begin
                        pend_val <= sat;
                        pend_vld <= 1'b1;
                    end
                end
                CONV_COMMIT: begin
                    digits_o <= bcd;
                    // A strobe landing in this cycle is the newest pending value, so it overrides the slot.
                    if (valid_i || pend_vld) begin
                        bin      <= valid_i ? sat : pend_val;
                        bcd      <= '0;
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                        state    <= CONV_SHIFT;
                    end else begin
                        state <= CONV_IDLE;
                    end
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_render.sv
// score_render: N-player BCD score overlay with 3x5 font, pixel scaling and post-update blink
//   clk_i, rst_i   : pixel clock, asynchronous active-high reset
//   pixel_x_i/y_i  : current pixel position
//   frame_start_i  : one-cycle pulse per frame, drives the blink timer
//   score_val_i    : packed binary scores, player p at [p*VAL_W +: VAL_W]
//   score_valid_i  : per-player load strobe
//   pos_x_i/pos_y_i: packed top-left corner per player
//   busy_o         : per-player conversion running or pending
//   on_score_o     : registered, pixel lit by any score (2-cycle latency from pixel)
//   display_rgb_o  : registered, SCORE_RGB when lit else 0
module score_render
    import score_pkg::*;
#(
    parameter int              N_PLAYERS     = 2,
    parameter int              DIGITS        = 2,
    parameter int              VAL_W         = 7,
    parameter int              SCALE_LOG2    = 2,
    parameter int              BLINK_FRAMES  = 16,
    parameter int              BLINK_TOGGLES = 6,
    parameter int              X_POS_W       = 10,
    parameter int              Y_POS_W       = 10,
    parameter int              RGB_W         = 12,
    parameter logic [RGB_W-1:0] SCORE_RGB    = '1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [X_POS_W-1:0]             pixel_x_i,
    input  logic [Y_POS_W-1:0]             pixel_y_i,
    input  logic                           frame_start_i,
    input  logic [N_PLAYERS*VAL_W-1:0]     score_val_i,
    input  logic [N_PLAYERS-1:0]           score_valid_i,
    input  logic [N_PLAYERS*X_POS_W-1:0]   pos_x_i,
    input  logic [N_PLAYERS*Y_POS_W-1:0]   pos_y_i,
    output logic [N_PLAYERS-1:0]           busy_o,
    output logic                           on_score_o,
    output logic [RGB_W-1:0]               display_rgb_o
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

    logic [N_PLAYERS-1:0] lit;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
        bcd_t [DIGITS-1:0]  digits;
        logic               commit;
        logic [DIGITS-1:0]  lead;
        logic [X_POS_W-1:0] px;
        logic [X_POS_W-1:0] lx;
        logic [Y_POS_W-1:0] py;
        logic [Y_POS_W-1:0] ly;
        logic               hit;
        logic [DIG_W-1:0]   sel;
        logic [TOG_W-1:0]   tog;
        logic [FC_W-1:0]    fcnt;
        logic               vis;
        logic               s1_hit;
        logic               s1_blank;
        bcd_t               s1_dig;
        logic [2:0]         s1_row;
        logic [1:0]         s1_col;

        score_bin2bcd #(
            .DIGITS (DIGITS),
            .VAL_W  (VAL_W)
        ) u_conv (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .val_i    (score_val_i[g*VAL_W +: VAL_W]),
            .valid_i  (score_valid_i[g]),
            .busy_o   (busy_o[g]),
            .commit_o (commit),
            .digits_o (digits)
        );

        assign px = pos_x_i[g*X_POS_W +: X_POS_W];
        assign py = pos_y_i[g*Y_POS_W +: Y_POS_W];
        assign lx = (pixel_x_i - px) >> SCALE_LOG2;
        assign ly = (pixel_y_i - py) >> SCALE_LOG2;
        // The explicit >= guards stop a pixel left of/above the score from wrapping into range.
        assign hit = (pixel_x_i >= px) && (pixel_y_i >= py) &&
                     (lx < X_POS_W'(CELL_W * DIGITS)) && (ly < Y_POS_W'(GLYPH_H));
        // Cells are laid out most significant first, digits[] is least significant first.
        assign sel = DIG_W'(DIGITS - 1) - lx[2 +: DIG_W];

        // lead[i]: digit i and every more significant digit are zero.
        always_comb begin
            logic z;
            z    = 1'b1;
            lead = '0;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                z       = z && (digits[i] == 4'd0);
                lead[i] = z;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                tog  <= '0;
                fcnt <= '0;
                vis  <= 1'b1;
            end else if (commit) begin
                tog  <= TOG_W'(BLINK_TOGGLES);
                fcnt <= '0;
                vis  <= 1'b0;
            end else if (frame_start_i && tog != '0) begin
                fcnt <= (fcnt == FC_W'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
                if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                    // The final toggle always leaves the score steadily visible.
                    vis <= (tog == TOG_W'(1)) || !vis;
                    tog <= tog - 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_hit   <= 1'b0;
                s1_blank <= 1'b0;
                s1_dig   <= '0;
                s1_row   <= '0;
                s1_col   <= '0;
            end else begin
                s1_hit   <= hit;
                s1_blank <= (sel != '0) && lead[sel];
                s1_dig   <= digits[sel];
                s1_row   <= ly[2:0];
                s1_col   <= lx[1:0];
            end
        end

        assign lit[g] = s1_hit && !s1_blank && vis && (s1_col < 2'(GLYPH_W)) &&
                        FONT_3X5[s1_dig][s1_row][2'd2 - s1_col];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            on_score_o    <= 1'b0;
            display_rgb_o <= '0;
        end else begin
            on_score_o    <= |lit;
            display_rgb_o <= (|lit) ? SCORE_RGB : '0;
        end
    end

endmodule

// File: tb/tb_score_render.sv
// tb_score_render: directed table and sequence bench for score_render
module tb_score_render;

    localparam int NP = 2;
    localparam int VW = 7;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int RW = 12;

    typedef struct {
        int p;
        int val;
        int x;
        int y;
        int exp;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [XW-1:0]     pixel_x_i = '0;
    logic [YW-1:0]     pixel_y_i = '0;
    logic              frame_start_i = 1'b0;
    logic [NP*VW-1:0]  score_val_i = '0;
    logic [NP-1:0]     score_valid_i = '0;
    logic [NP*XW-1:0]  pos_x_i = {10'd300, 10'd100};
    logic [NP*YW-1:0]  pos_y_i = {10'd40, 10'd20};
    logic [NP-1:0]     busy_o;
    logic              on_score_o;
    logic [RW-1:0]     display_rgb_o;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl [26];
    int cur [NP];
    int obs [26];

    always #5 clk_i = ~clk_i;

    score_render #(
        .N_PLAYERS (NP),
        .VAL_W     (VW),
        .X_POS_W   (XW),
        .Y_POS_W   (YW),
        .RGB_W     (RW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pixel_x_i     (pixel_x_i),
        .pixel_y_i     (pixel_y_i),
        .frame_start_i (frame_start_i),
        .score_val_i   (score_val_i),
        .score_valid_i (score_valid_i),
        .pos_x_i       (pos_x_i),
        .pos_y_i       (pos_y_i),
        .busy_o        (busy_o),
        .on_score_o    (on_score_o),
        .display_rgb_o (display_rgb_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic probe(input int x, input int y, input int exp, input string name);
        pixel_x_i = XW'(x);
        pixel_y_i = YW'(y);
        @(negedge clk_i);
        @(negedge clk_i);
        check({name, "_on"}, int'(on_score_o), exp);
        check({name, "_rgb"}, int'(display_rgb_o), exp ? 4095 : 0);
    endtask

    task automatic strobe(input int p, input int v);
        score_val_i[p*VW +: VW] = VW'(v);
        score_valid_i[p] = 1'b1;
        @(negedge clk_i);
        score_valid_i[p] = 1'b0;
    endtask

    task automatic wait_idle(input int p);
        int n;
        n = 0;
        while (busy_o[p] && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("busy_clears", int'(busy_o[p]), 0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start_i = 1'b1;
            @(negedge clk_i);
            frame_start_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic load(input int p, input int v);
        strobe(p, v);
        wait_idle(p);
        frames(96);
        cur[p] = v;
    endtask

    task automatic busy_run(input int p, inout int run);
        while (busy_o[p] && run < 64) begin
            run++;
            @(negedge clk_i);
        end
    endtask

    function automatic int vis_exp(input int k);
        return (k >= 96 || ((k / 16) % 2) == 1) ? 1 : 0;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int run;
        int k;
        int first;
        int last;
        int cnt;
        int pts [13];
        tbl = '{
            '{0, 42, 100, 20, 1}, '{0, 42, 103, 23, 1}, '{0, 42, 104, 20, 0}, '{0, 42, 112, 20, 0},
            '{0, 42, 116, 24, 0}, '{0, 42, 124, 24, 1}, '{0, 42, 127, 20, 1}, '{0, 42, 128, 20, 0},
            '{0, 42, 132, 20, 0}, '{0, 42,  99, 20, 0}, '{0, 42, 116, 40, 0},
            '{0, 120, 120, 28, 1}, '{0, 120, 104, 36, 1}, '{0, 120, 100, 32, 0},
            '{0, 7, 100, 20, 0}, '{0, 7, 108, 28, 0}, '{0, 7, 116, 20, 1}, '{0, 7, 116, 24, 0},
            '{0, 7, 124, 36, 1}, '{0, 0, 116, 20, 1}, '{0, 0, 100, 20, 0},
            '{0, 10, 104, 20, 1}, '{0, 10, 120, 24, 0},
            '{1, 5, 316, 40, 1}, '{1, 5, 316, 44, 1}, '{1, 5, 324, 44, 0}
        };
        pts = '{0, 8, 15, 16, 31, 32, 47, 48, 64, 80, 95, 96, 100};
        cur[0] = 0;
        cur[1] = 0;

        // Reset state and abandoning a conversion with a pending value
        repeat (3) @(negedge clk_i);
        check("rst_busy", int'(busy_o), 0);
        rst_i = 1'b0;
        check("rst_on", int'(on_score_o), 0);
        check("rst_rgb", int'(display_rgb_o), 0);
        probe(116, 20, 1, "rst_zero_shown");
        probe(100, 20, 0, "rst_tens_blank");
        probe(116, 20, 1, "pre_rst_lit");
        strobe(0, 55);
        strobe(0, 66);
        check("mid_busy", int'(busy_o[0]), 1);
        rst_i = 1'b1;
        #1;
        check("async_busy", int'(busy_o), 0);
        check("async_on", int'(on_score_o), 0);
        check("async_rgb", int'(display_rgb_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("post_rst_busy", int'(busy_o), 0);
        probe(124, 24, 1, "post_rst_zero");
        probe(116, 20, 1, "post_rst_noblink");

        // Convert 42: busy for VAL_W+1 cycles, hidden right after commit
        strobe(0, 42);
        run = 0;
        busy_run(0, run);
        check("busy_len_42", run, 8);
        probe(100, 20, 0, "blink_off_42");
        frames(96);
        cur[0] = 42;
        probe(100, 20, 1, "lit_42");
        probe(112, 20, 0, "gap_42");

        // Rendering table
        for (int i = 0; i < 26; i++) begin
            if (tbl[i].val != cur[tbl[i].p]) load(tbl[i].p, tbl[i].val);
            probe(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Back-to-back strobes: 11 is replaced by 12 in the pending slot
        run = 0;
        score_val_i[0 +: VW] = 7'd10;
        score_valid_i[0] = 1'b1;
        @(negedge clk_i);
        run += int'(busy_o[0]);
        score_val_i[0 +: VW] = 7'd11;
        @(negedge clk_i);
        run += int'(busy_o[0]);
        score_val_i[0 +: VW] = 7'd12;
        @(negedge clk_i);
        score_valid_i[0] = 1'b0;
        busy_run(0, run);
        check("busy_len_b2b", run, 16);
        frames(96);
        cur[0] = 12;
        probe(116, 24, 0, "b2b_ones_r1c0");
        probe(124, 28, 1, "b2b_ones_r2c2");
        probe(104, 20, 1, "b2b_tens");

        // Blink pattern after a commit
        strobe(0, 42);
        wait_idle(0);
        cur[0] = 42;
        k = 0;
        for (int i = 0; i < 13; i++) begin
            frames(pts[i] - k);
            k = pts[i];
            probe(100, 20, vis_exp(k), $sformatf("blink_k%0d", k));
        end

        // A commit mid-blink restarts the pattern
        strobe(0, 42);
        wait_idle(0);
        frames(40);
        probe(100, 20, 0, "restart_pre");
        strobe(0, 42);
        wait_idle(0);
        probe(100, 20, 0, "restart_n0");
        frames(8);
        probe(100, 20, 0, "restart_n8");
        frames(8);
        probe(100, 20, 1, "restart_n16");
        frames(48);
        probe(100, 20, 0, "restart_n64");
        frames(32);
        probe(100, 20, 1, "restart_n96");

        // frame_start in the COMMIT cycle is not counted
        score_val_i[0 +: VW] = 7'd42;
        score_valid_i[0] = 1'b1;
        @(negedge clk_i);
        score_valid_i[0] = 1'b0;
        repeat (7) @(negedge clk_i);
        check("commit_cycle_busy", int'(busy_o[0]), 1);
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        check("after_commit_busy", int'(busy_o[0]), 0);
        frames(15);
        probe(100, 20, 0, "coinc_k15");
        frames(1);
        probe(100, 20, 1, "coinc_k16");
        frames(80);

        // Row sweep through the tens glyph column 2 of "4"
        pixel_x_i = 10'd108;
        for (int i = 0; i < 26; i++) begin
            obs[i] = int'(on_score_o);
            pixel_y_i = YW'(19 + i);
            @(negedge clk_i);
        end
        first = -1;
        last = -1;
        cnt = 0;
        for (int i = 2; i < 26; i++) begin
            if (obs[i] != 0) begin
                if (first < 0) first = 19 + i - 2;
                last = 19 + i - 2;
                cnt++;
            end
        end
        check("sweep_first_row", first, 20);
        check("sweep_last_row", last, 39);
        check("sweep_lit_rows", cnt, 20);

        // Position boundaries
        pos_x_i[XW +: XW] = 10'd0;
        probe(1023, 40, 0, "posx0_far_miss");
        probe(16, 40, 1, "posx0_ones_hit");
        pos_x_i[XW +: XW] = 10'd1010;
        probe(2, 40, 0, "wrap_miss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
